// File: rtl/tlvds_rx_monitor.sv
// Receive monitor for a TLVDS differential input: synchronizes, glitch-filters and edge-detects the
// received level, measures the rising-edge period, and tracks lock / loss-of-signal.
module tlvds_rx_monitor #(
    parameter int FILTER_LEN  = 4,
    parameter int PERIOD_W    = 25,
    parameter int TIMEOUT_CYC = 16777216
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tlvds_p,
    input  logic                tlvds_n,
    output logic                rx_level,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_stb,
    output logic                locked,
    output logic                los
);

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCNT_W-1:0]   FCNT_LAST    = FCNT_W'(FILTER_LEN - 1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = PERIOD_W'(TIMEOUT_CYC - 1);
    localparam logic [PERIOD_W-1:0] PCNT_SAT     = '1;

    typedef enum logic [1:0] {
        ST_LOS     = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic                ibuf_o;
    logic                s1_q, s2_q;
    logic                level_q, level_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                stb_q, stb_d;
    logic                locked_q, locked_d;
    logic                los_q, los_d;

    // Behavioural stand-in for the TLVDS_IBUF comparator: true leg high and complement low reads as 1.
    assign ibuf_o = tlvds_p & ~tlvds_n;

    always_comb begin
        level_d = level_q;
        fcnt_d  = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != level_q) begin
            if (fcnt_q == FCNT_LAST) begin
                level_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // The FSM reacts to the rise detected this cycle, so los/locked/period move on the same edge as rise_pulse.
    always_comb begin
        state_d  = state_q;
        los_d    = los_q;
        locked_d = locked_q;
        period_d = period_q;
        stb_d    = 1'b0;
        pcnt_d   = (pcnt_q == PCNT_SAT) ? pcnt_q : pcnt_q + 1'b1;
        case (state_q)
            ST_LOS: begin
                pcnt_d = '0;
                if (rise_d) begin
                    state_d = ST_ACQUIRE;
                    los_d   = 1'b0;
                end
            end
            ST_ACQUIRE, ST_LOCKED: begin
                if (rise_d) begin
                    state_d  = ST_LOCKED;
                    pcnt_d   = '0;
                    period_d = pcnt_q + 1'b1;
                    stb_d    = 1'b1;
                    locked_d = 1'b1;
                end else if (pcnt_q == TIMEOUT_LAST) begin
                    state_d  = ST_LOS;
                    pcnt_d   = '0;
                    period_d = '0;
                    locked_d = 1'b0;
                    los_d    = 1'b1;
                end
            end
            default: begin
                state_d  = ST_LOS;
                pcnt_d   = '0;
                period_d = '0;
                locked_d = 1'b0;
                los_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            level_q  <= 1'b0;
            fcnt_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            state_q  <= ST_LOS;
            pcnt_q   <= '0;
            period_q <= '0;
            stb_q    <= 1'b0;
            locked_q <= 1'b0;
            los_q    <= 1'b1;
        end else begin
            s1_q     <= ibuf_o;
            s2_q     <= s1_q;
            level_q  <= level_d;
            fcnt_q   <= fcnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            stb_q    <= stb_d;
            locked_q <= locked_d;
            los_q    <= los_d;
        end
    end

    assign rx_level   = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign period     = period_q;
    assign period_stb = stb_q;
    assign locked     = locked_q;
    assign los        = los_q;

endmodule

// File: tb/tb_tlvds_rx_monitor.sv
// Bench for tlvds_rx_monitor: filter vectors from a table, then lock, timeout, rise-on-timeout and
// mid-run reset sequences; measured periods are checked against an expected queue.
module tb_tlvds_rx_monitor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tlvds_p;
    logic         tlvds_n;
    logic         rx_level;
    logic         rise_pulse;
    logic         fall_pulse;
    logic [W-1:0] period;
    logic         period_stb;
    logic         locked;
    logic         los;

    tlvds_rx_monitor #(
        .FILTER_LEN (4),
        .PERIOD_W   (W),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tlvds_p   (tlvds_p),
        .tlvds_n   (tlvds_n),
        .rx_level  (rx_level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .period    (period),
        .period_stb(period_stb),
        .locked    (locked),
        .los       (los)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic p;
        int   cycles;
        logic exp_level;
        int   exp_rises;
        int   exp_falls;
    } vec_t;

    vec_t         vecs[12];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           rise_cnt = 0;
    int           fall_cnt = 0;
    int           last_rise_cyc = 0;
    logic         snap_los = 1'b0;
    logic         snap_locked = 1'b0;
    logic         los_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard sink: every period strobe consumes one expected period.
    always @(negedge clk) begin
        if (rst_n && period_stb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL period_stb_unexpected: got strobe with period %0d, expected none (t=%0t)",
                         period, $time);
            end else begin
                check("period", 32'(period), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rise_pulse) begin
            rise_cnt++;
            last_rise_cyc = cyc;
            snap_los      = los;
            snap_locked   = locked;
        end
        if (fall_pulse) fall_cnt++;
        if (los) los_seen = 1'b1;
        check("pulse_exclusive", 32'(rise_pulse & fall_pulse), 0);
    endtask

    task automatic drive(input logic p, input int n);
        tlvds_p = p;
        tlvds_n = ~p;
        repeat (n) step();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        drive(1'b0, 2);
        rst_n = 1'b1;
    endtask

    task automatic rise_cycle(input int h, input int l, input bit do_push, input int exp_p,
                              input logic exp_locked, input string tag);
        int r0;
        r0 = rise_cnt;
        if (do_push) exp_q.push_back(W'(exp_p));
        drive(1'b1, h);
        check({tag, "_rise_count"}, 32'(rise_cnt - r0), 1);
        check({tag, "_los_at_rise"}, 32'(snap_los), 0);
        check({tag, "_locked_at_rise"}, 32'(snap_locked), 32'(exp_locked));
        if (l > 0) drive(1'b0, l);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_level"}, 32'(rx_level), 0);
        check({tag, "_rise_pulse"}, 32'(rise_pulse), 0);
        check({tag, "_fall_pulse"}, 32'(fall_pulse), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_period_stb"}, 32'(period_stb), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_los"}, 32'(los), 1);
    endtask

    initial begin
        int r0;
        int f0;
        rst_n   = 1'b0;
        tlvds_p = 1'b0;
        tlvds_n = 1'b1;

        // {p, cycles held, rx_level after, rises during, falls during}
        vecs[0]  = '{1'b1, 3,  1'b0, 0, 0};
        vecs[1]  = '{1'b0, 8,  1'b0, 0, 0};
        vecs[2]  = '{1'b1, 8,  1'b1, 1, 0};
        vecs[3]  = '{1'b0, 2,  1'b1, 0, 0};
        vecs[4]  = '{1'b1, 8,  1'b1, 0, 0};
        vecs[5]  = '{1'b0, 3,  1'b1, 0, 0};
        vecs[6]  = '{1'b1, 8,  1'b1, 0, 0};
        vecs[7]  = '{1'b0, 8,  1'b0, 0, 1};
        vecs[8]  = '{1'b1, 1,  1'b0, 0, 0};
        vecs[9]  = '{1'b0, 40, 1'b0, 0, 0};
        vecs[10] = '{1'b1, 6,  1'b1, 1, 0};
        vecs[11] = '{1'b0, 6,  1'b0, 0, 1};

        @(posedge clk);
        #1;
        check_reset_outputs("init");
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            r0 = rise_cnt;
            f0 = fall_cnt;
            drive(vecs[i].p, vecs[i].cycles);
            check($sformatf("vec%0d_level", i), 32'(rx_level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_rises", i), 32'(rise_cnt - r0), 32'(vecs[i].exp_rises));
            check($sformatf("vec%0d_falls", i), 32'(fall_cnt - f0), 32'(vecs[i].exp_falls));
        end

        // Exact filter latency: level rises on the 6th edge after the input change.
        reset_pulse();
        drive(1'b1, 5);
        check("latency_edge5_level", 32'(rx_level), 0);
        drive(1'b1, 1);
        check("latency_edge6_level", 32'(rx_level), 1);
        check("latency_edge6_rise", 32'(rise_pulse), 1);
        drive(1'b1, 1);
        check("latency_edge7_rise", 32'(rise_pulse), 0);

        // Lock and measure a 10/10 square wave.
        reset_pulse();
        rise_cycle(10, 10, 1'b0, 0, 1'b0, "sq_r1");
        check("sq_locked_before_r2", 32'(locked), 0);
        for (int r = 2; r <= 5; r++) rise_cycle(10, 10, 1'b1, 20, 1'b1, $sformatf("sq_r%0d", r));

        // Rises exactly TIMEOUT_CYC apart must not drop lock.
        los_seen = 1'b0;
        rise_cycle(10, 54, 1'b1, 20, 1'b1, "edge_r1");
        rise_cycle(10, 54, 1'b1, 64, 1'b1, "edge_r2");
        rise_cycle(10, 54, 1'b1, 64, 1'b1, "edge_r3");
        check("edge_no_los", 32'(los_seen), 0);
        check("edge_locked_holds", 32'(locked), 1);

        // Stop toggling after a rise: LOS exactly 64 cycles after that rise.
        rise_cycle(10, 0, 1'b1, 64, 1'b1, "los_r");
        tlvds_p = 1'b0;
        tlvds_n = 1'b1;
        for (int k = 0; k < 200 && !los; k++) step();
        check("los_asserted", 32'(los), 1);
        check("los_delay", 32'(cyc - last_rise_cyc), 64);
        check("los_locked", 32'(locked), 0);
        check("los_period", 32'(period), 0);

        // Re-lock, then an asynchronous reset between clock edges.
        rise_cycle(10, 10, 1'b0, 0, 1'b0, "reacq");
        rise_cycle(10, 10, 1'b1, 20, 1'b1, "relock");
        rise_cycle(10, 0, 1'b1, 20, 1'b1, "prerst");
        check("prerst_level", 32'(rx_level), 1);
        check("prerst_locked", 32'(locked), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        drive(1'b0, 2);
        rst_n = 1'b1;
        rise_cycle(10, 10, 1'b0, 0, 1'b0, "post_r1");
        check("post_locked_before_r2", 32'(locked), 0);
        rise_cycle(10, 10, 1'b1, 20, 1'b1, "post_r2");
        rise_cycle(10, 10, 1'b1, 20, 1'b1, "post_r3");

        repeat (4) step();
        check("stb_all_consumed", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
